e16_out_monitor: RTL

E16_OUT_MONITOR -- requirements
Module: e16_out_monitor

---
 rtl/e16_mon_pkg.sv | 11 +
 rtl/e16_code_check.sv | 12 +
 rtl/e16_out_monitor.sv | 83 ++++++++
 3 files changed

// File: rtl/e16_mon_pkg.sv
// e16_mon_pkg: shared width, state encoding and legal output words for the e16 output monitor
package e16_mon_pkg;
  localparam int Y_W = 18;
  localparam int N_LEGAL = 17;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ALERT = 2'd2, LOCK = 2'd3} mon_state_t;
  localparam logic [Y_W-1:0] LEGAL [N_LEGAL] = '{
    18'h00000, 18'h00001, 18'h00002, 18'h00004, 18'h00008, 18'h00010, 18'h00020,
    18'h00200, 18'h01000, 18'h02000, 18'h04000, 18'h08000,
    18'h20800, 18'h10080, 18'h000C0, 18'h00C01, 18'h00D00
  };
endpackage

// File: rtl/e16_code_check.sv
// e16_code_check: flags any output word outside the legal e16 word set
module e16_code_check
  import e16_mon_pkg::*;
(
  input  logic [Y_W-1:0] y,
  output logic           illegal
);
  always_comb begin
    illegal = 1'b1;
    for (int i = 0; i < N_LEGAL; i++) illegal = (y == LEGAL[i]) ? 1'b0 : illegal;
  end
endmodule

// File: rtl/e16_out_monitor.sv
// e16_out_monitor: silent-run / illegal-word watchdog for e16 outputs; E16_MON_HIST_EN adds an 8-deep history buffer
module e16_out_monitor
  import e16_mon_pkg::*;
#(
  parameter int SILENT_LIMIT = 16,
  parameter int VIOL_LOCK    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           clear,
  input  logic [Y_W-1:0] y_vec,
`ifdef E16_MON_HIST_EN
  input  logic [2:0]     hist_idx,
  output logic [Y_W-1:0] hist_data,
`endif
  output logic           alarm,
  output logic           lock,
  output logic           silent_err,
  output logic           illegal_err,
  output logic [1:0]     viol_cnt,
  output logic [15:0]    act_cnt,
  output logic [1:0]     mon_state
);
  mon_state_t     state, state_n;
  logic [Y_W-1:0] y_q;
  logic [7:0]     silent_run;
  logic           illegal, armed, nz, silent_hit, ill_hit, viol;
  logic [1:0]     viol_nxt;
  e16_code_check u_chk (.y(y_q), .illegal(illegal));
  assign armed      = state == ARMED;
  assign nz         = |y_q;
  assign silent_hit = armed && silent_run == 8'(SILENT_LIMIT);
  assign ill_hit    = armed && illegal;
  assign viol       = silent_hit || ill_hit;
  assign viol_nxt   = (viol_cnt == 2'd3) ? 2'd3 : viol_cnt + 2'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE && start) ? ARMED :
              (armed && viol) ? ((viol_nxt >= 2'(VIOL_LOCK)) ? LOCK : ALERT) :
              (state == ALERT && clear) ? ARMED : state;
  end
  always_comb begin
    alarm     = state == ALERT || state == LOCK;
    lock      = state == LOCK;
    mon_state = state;
  end
  // counters only move while ARMED; ALERT freezes everything until clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q         <= '0;
      silent_run  <= '0;
      act_cnt     <= '0;
      viol_cnt    <= '0;
      silent_err  <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      y_q <= y_vec;
      if (armed) begin
        silent_run  <= nz ? 8'd0 : (silent_run == 8'hFF) ? silent_run : silent_run + 8'd1;
        act_cnt     <= act_cnt + 16'(nz);
        viol_cnt    <= viol ? viol_nxt : viol_cnt;
        silent_err  <= silent_err | silent_hit;
        illegal_err <= illegal_err | ill_hit;
      end else if (state == ALERT && clear) silent_run <= 8'd0;
    end
`ifdef E16_MON_HIST_EN
  logic [Y_W-1:0] hist [8];
  logic [2:0]     wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      for (int i = 0; i < 8; i++) hist[i] <= '0;
    end else if (armed && nz) begin
      hist[wp] <= y_q;
      wp       <= wp + 3'd1;
    end
  assign rp        = wp - 3'd1 - hist_idx;
  assign hist_data = hist[rp];
`endif
endmodule
